// File: rtl/io_uart_rx.sv
// UART receiver (8N1, mid-bit sampling) with a show-ahead receive FIFO and sticky error flags.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module io_uart_rx #(
    parameter int unsigned BIT_CYCLES = 868,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    input  logic       rx_i,
    output logic       rx_oeb_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    input  logic       err_clr_i
);

    localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] HALF_LOAD = 16'(BIT_CYCLES / 2 - 1);
    localparam logic [15:0] BIT_LOAD  = 16'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        sync1_q, rxs_q, prev_q;
    logic [1:0]  warm_q;
    logic        push, ferr_set, par_err;
    logic [AW:0] wr_q, rd_q;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic        full, pop, push_ok, ovr_set;
    logic        ferr_q, ovr_q;

    assign rx_oeb_o = 1'b1;

    // prev_q only tracks rxs once the synchronizer holds real pad data, so a line
    // held low through reset release never looks like a falling edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            warm_q  <= '0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            rxs_q   <= sync1_q;
            warm_q  <= {warm_q[0], 1'b1};
            prev_q  <= warm_q[1] & rxs_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    assign par_err = ^{sh_q, par_q};
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q != '0) ? cnt_q - 16'd1 : cnt_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        push     = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (prev_q && !rxs_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (!rxs_q) begin
                        state_d = S_DATA;
                        cnt_d   = BIT_LOAD;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    sh_d  = {rxs_q, sh_q[7:1]};
                    cnt_d = BIT_LOAD;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == '0) begin
                    par_d   = rxs_q;
                    cnt_d   = BIT_LOAD;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    if (rxs_q && !par_err) push = 1'b1;
                    else                   ferr_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pop     = valid_o && ready_i;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push_ok = push && (!full || pop);
    assign ovr_set = push && full && !pop;
    assign valid_o = (wr_q != rd_q);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (pop) rd_q <= rd_q + 1'b1;
            if (push_ok) begin
                mem_q[wr_q[AW-1:0]] <= sh_q;
                wr_q                <= wr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            if (ferr_set)       ferr_q <= 1'b1;
            else if (err_clr_i) ferr_q <= 1'b0;
            if (ovr_set)        ovr_q  <= 1'b1;
            else if (err_clr_i) ovr_q  <= 1'b0;
        end
    end

    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_io_uart_rx.sv
// Directed self-checking bench for io_uart_rx, 8N1 build, BIT_CYCLES=16, FIFO_DEPTH=4.
module tb_io_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_oeb;
    logic [7:0] data;
    logic       valid;
    logic       ready = 1'b0;
    logic       ferr;
    logic       ovr;
    logic       err_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    io_uart_rx #(.BIT_CYCLES(16), .FIFO_DEPTH(4)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .rx_i        (rx),
        .rx_oeb_o    (rx_oeb),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .frame_err_o (ferr),
        .overrun_o   (ovr),
        .err_clr_i   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame starts at the current (posedge+1) time; returns one stop-bit period later.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(16);
        end
        rx = stop;
        tick(16);
        rx = 1'b1;
    endtask

    task automatic pop_one();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    task automatic test_reset();
        tick(2);
        checks++; if (rx_oeb !== 1'b1) begin failures++; $display("FAIL oeb_in_reset: got %b expected 1", rx_oeb); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL valid_in_reset: got %b expected 0", valid); end
        rst_n = 1'b1;
        tick(4);
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL data_reset: got %h expected 00", data); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL valid_reset: got %b expected 0", valid); end
        checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL ferr_reset: got %b expected 0", ferr); end
        checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL ovr_reset: got %b expected 0", ovr); end
        checks++; if (rx_oeb !== 1'b1) begin failures++; $display("FAIL oeb_reset: got %b expected 1", rx_oeb); end
    endtask

    task automatic test_single_byte();
        fork
            send_frame(8'hA5, 1'b1);
            begin
                tick(154);
                checks++; if (valid !== 1'b0) begin failures++; $display("FAIL valid_before_stop: got %b expected 0", valid); end
                tick(1);
                checks++; if (valid !== 1'b1) begin failures++; $display("FAIL valid_after_stop: got %b expected 1", valid); end
            end
        join
        checks++; if (data !== 8'hA5) begin failures++; $display("FAIL single_data: got %h expected a5", data); end
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b expected 1", valid); end
        checks++; if ({ferr, ovr} !== 2'b00) begin failures++; $display("FAIL single_flags: got %b expected 00", {ferr, ovr}); end
        pop_one();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL single_pop: got %b expected 0", valid); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL glitch_valid: got %b expected 0", valid); end
        checks++; if ({ferr, ovr} !== 2'b00) begin failures++; $display("FAIL glitch_flags: got %b expected 00", {ferr, ovr}); end
        send_frame(8'h3C, 1'b1);
        checks++; if (data !== 8'h3C) begin failures++; $display("FAIL glitch_next_data: got %h expected 3c", data); end
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL glitch_next_valid: got %b expected 1", valid); end
        pop_one();
    endtask

    task automatic test_framing();
        send_frame(8'h55, 1'b0);
        tick(2);
        checks++; if (ferr !== 1'b1) begin failures++; $display("FAIL ferr_set: got %b expected 1", ferr); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ferr_valid: got %b expected 0", valid); end
        checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL ferr_ovr: got %b expected 0", ovr); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL ferr_clear: got %b expected 0", ferr); end
    endtask

    task automatic test_overrun_wrap();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        checks++; if (ovr !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b expected 1", ovr); end
        checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL ovr_ferr: got %b expected 0", ferr); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (valid !== 1'b1) begin failures++; $display("FAIL ovr_valid_%0d: got %b expected 1", i, valid); end
            checks++; if (data !== 8'(i)) begin failures++; $display("FAIL ovr_data_%0d: got %h expected %h", i, data, 8'(i)); end
            pop_one();
        end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ovr_drained: got %b expected 0", valid); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b expected 0", ovr); end
        for (int i = 6; i <= 9; i++) send_frame(8'(i), 1'b1);
        checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL wrap_ovr: got %b expected 0", ovr); end
        checks++; if (data !== 8'h06) begin failures++; $display("FAIL wrap_head: got %h expected 06", data); end
    endtask

    task automatic test_full_push_pop();
        fork
            send_frame(8'h0A, 1'b1);
            begin
                tick(154);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
            end
        join
        checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL pushpop_ovr: got %b expected 0", ovr); end
        for (int i = 7; i <= 10; i++) begin
            checks++; if (valid !== 1'b1) begin failures++; $display("FAIL pushpop_valid_%0d: got %b expected 1", i, valid); end
            checks++; if (data !== 8'(i)) begin failures++; $display("FAIL pushpop_data_%0d: got %h expected %h", i, data, 8'(i)); end
            pop_one();
        end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL pushpop_empty: got %b expected 0", valid); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h5A, 1'b1);
        rx = 1'b0;
        tick(16 + 48 + 8);
        #2 rst_n = 1'b0;
        tick(3);
        checks++; if (rx_oeb !== 1'b1) begin failures++; $display("FAIL mid_oeb: got %b expected 1", rx_oeb); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mid_valid_rst: got %b expected 0", valid); end
        rst_n = 1'b1;
        tick(200);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mid_valid_low: got %b expected 0", valid); end
        checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL mid_no_frame: got %b expected 0", ferr); end
        rx = 1'b1;
        tick(20);
        send_frame(8'hC3, 1'b1);
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL mid_next_valid: got %b expected 1", valid); end
        checks++; if (data !== 8'hC3) begin failures++; $display("FAIL mid_next_data: got %h expected c3", data); end
        checks++; if ({ferr, ovr} !== 2'b00) begin failures++; $display("FAIL mid_next_flags: got %b expected 00", {ferr, ovr}); end
        pop_one();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mid_final_pop: got %b expected 0", valid); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_framing();
        test_overrun_wrap();
        test_full_push_pop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
